// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory, decode and redirect signals of the fetch stage.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        redirect;
  logic [31:0] redirect_pc;
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, fetches one instruction at a time and hands it to decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        discard_q, discard_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_pc4_q, inst_pc4_d;
  logic [31:0] redir_pc;
  assign redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_pc4_d = inst_pc4_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        state_d    = bus.imem_gnt ? WAIT : REQ;
        fetch_pc_d = bus.imem_gnt ? pc_q : fetch_pc_q;
        pc_d       = bus.redirect ? redir_pc : pc_q;
        // a grant in the redirect cycle was for the old PC
        discard_d  = bus.redirect && bus.imem_gnt;
      end
      WAIT: begin
        if (bus.imem_rvalid && (discard_q || bus.redirect)) begin
          state_d   = REQ;
          discard_d = 1'b0;
          pc_d      = bus.redirect ? redir_pc : pc_q;
        end else if (bus.imem_rvalid) begin
          state_d    = HOLD;
          inst_d     = bus.imem_rdata;
          inst_pc_d  = fetch_pc_q;
          inst_pc4_d = fetch_pc_q + 32'd4;
          pc_d       = fetch_pc_q + 32'd4;
        end else if (bus.redirect) begin
          pc_d      = redir_pc;
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        state_d = (bus.inst_ready || bus.redirect) ? REQ : HOLD;
        pc_d    = bus.redirect ? redir_pc : pc_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_pc4_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_pc4_q <= inst_pc4_d;
    end
  end
  assign bus.imem_req   = state_q == REQ;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = state_q == HOLD;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_pc4   = inst_pc4_q;
endmodule
